seq_alu: RTL and testbench

Parametrised, registered multi-cycle ALU. It generalises the team's 3-bit combinational add/sub/equality/halve ALU to WIDTH-bit operands and adds a start/busy/done handshake. It also adds iterative multiply and divide, with divide-by-zero and illegal-opcode flagging. It sits between the switch/operand capture logic and the display driver: a single start pulse launches an operation, and the result is held until the next one.

---
 rtl/seq_alu.sv | 146 ++++++++++++++
 tb/tb_seq_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU with a start/busy/done handshake: add/sub/equal/halve/reserved finish in
// 1 cycle, mul/div take WIDTH+2. A start while busy is dropped, not queued; q holds until the next write.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         swSelect,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] q,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_EQ    = 3'b010;
  localparam logic [2:0] OP_HALVE = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   q_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 is_div_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;

  logic [2*WIDTH-1:0]   imm_d;
  logic                 imm_err_d;
  logic                 imm_multi_d;
  logic [WIDTH:0]       add_w;
  logic [WIDTH:0]       sub_w;
  logic [WIDTH:0]       msum;
  logic [2*WIDTH-1:0]   mul_step_d;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;
  logic [2*WIDTH-1:0]   div_step_d;
  logic [2*WIDTH-1:0]   final_d;
  logic                 final_err_d;

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  // Single-cycle results are formed straight from the inputs sampled at the accepting edge.
  always_comb begin
    imm_d       = '0;
    imm_err_d   = 1'b0;
    imm_multi_d = 1'b0;
    add_w       = {1'b0, a} + {1'b0, b};
    sub_w       = {1'b0, a} - {1'b0, b};
    case (swSelect)
      OP_ADD:   imm_d[WIDTH:0] = add_w;
      OP_SUB:   imm_d[WIDTH:0] = sub_w;
      OP_EQ:    imm_d[0] = (a == b);
      OP_HALVE: imm_d[WIDTH-2:0] = a[WIDTH-1:1];
      OP_MUL,
      OP_DIV:   imm_multi_d = 1'b1;
      default:  imm_err_d = 1'b1;
    endcase
  end

  // acc_q holds {partial_hi, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    msum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step_d = {msum, acc_q[WIDTH-1:1]};

    div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, b_q});
    div_sub    = div_shift[WIDTH-1:0] - b_q;
    div_step_d = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                        : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    final_d     = acc_q;
    final_err_d = 1'b0;
    if (is_div_q && (b_q == '0)) begin
      final_d     = {a_q, {WIDTH{1'b1}}};
      final_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      q_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      is_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            is_div_q <= (swSelect == OP_DIV);
            err_q    <= imm_err_d;
            if (imm_multi_d) begin
              acc_q   <= (swSelect == OP_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
              cnt_q   <= CW'(WIDTH);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              q_q    <= imm_d;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          done_q <= 1'b0;
          if (cnt_q != '0) begin
            acc_q <= is_div_q ? div_step_d : mul_step_d;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            q_q     <= final_d;
            err_q   <= final_err_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed checks of seq_alu at WIDTH=4, plus a short random sweep at WIDTH=3 and WIDTH=8.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  logic       start4 = 1'b0;
  logic [2:0] sel4 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] q4;
  logic       busy4, done4, err4;

  seq_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .swSelect(sel4), .a(a4), .b(b4),
    .q(q4), .busy(busy4), .done(done4), .err(err4)
  );

  int          cur_w = 0;
  logic        start_s = 1'b0;
  logic [2:0]  sel_s = '0;
  logic [7:0]  a_s = '0, b_s = '0;
  logic [5:0]  q3;
  logic [15:0] q8;
  logic        busy3, done3, err3, busy8, done8, err8;
  logic        start3, start8;

  assign start3 = start_s && (cur_w == 3);
  assign start8 = start_s && (cur_w == 8);

  seq_alu #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .swSelect(sel_s), .a(a_s[2:0]), .b(b_s[2:0]),
    .q(q3), .busy(busy3), .done(done3), .err(err3)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .swSelect(sel_s), .a(a_s), .b(b_s),
    .q(q8), .busy(busy8), .done(done8), .err(err8)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Launch one op on the WIDTH=4 instance and check latency, result, err, hold and busy behaviour.
  task automatic do_op4(input logic [2:0] op, input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] exp_q, input logic exp_err, input bit poke,
                        input string tag);
    logic [7:0] prev_q;
    int         edges;
    int         exp_edges;
    bit         hold_ok;
    bit         busy_ok;
    prev_q  = q4;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    sel4 = op; a4 = av; b4 = bv; start4 = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    start4 = 1'b0; sel4 = 3'b000; a4 = ~av; b4 = ~bv;
    while (!done4 && edges < 20) begin
      if (q4 !== prev_q) hold_ok = 1'b0;
      if (busy4 !== 1'b1) busy_ok = 1'b0;
      if (poke) start4 = (edges == 2);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start4 = 1'b0;
    exp_edges = (op == 3'b100 || op == 3'b101) ? 5 : 0;
    expect_eq({tag, " latency"}, edges, exp_edges);
    expect_eq({tag, " q"}, q4, exp_q);
    expect_eq({tag, " err"}, err4, exp_err);
    expect_eq({tag, " busy_at_done"}, busy4, 1'b0);
    if (exp_edges != 0) begin
      expect_eq({tag, " q_hold"}, hold_ok, 1'b1);
      expect_eq({tag, " busy_run"}, busy_ok, 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    expect_eq({tag, " done_fall"}, done4, 1'b0);
    expect_eq({tag, " q_held"}, q4, exp_q);
  endtask

  function automatic void model(input int w, input logic [2:0] op, input int av, input int bv,
                                output logic [15:0] r, output logic e);
    int mask;
    mask = (1 << w) - 1;
    e = 1'b0;
    case (op)
      3'd0: r = 16'(av + bv);
      3'd1: r = 16'((av - bv) & ((1 << (w + 1)) - 1));
      3'd2: r = (av == bv) ? 16'd1 : 16'd0;
      3'd3: r = 16'(av / 2);
      3'd4: r = 16'(av * bv);
      3'd5: begin
        if (bv == 0) begin
          r = 16'((av << w) | mask);
          e = 1'b1;
        end else begin
          r = 16'(((av % bv) << w) | (av / bv));
        end
      end
      default: begin
        r = 16'd0;
        e = 1'b1;
      end
    endcase
  endfunction

  task automatic rand_ops(input int w, input int n);
    logic [15:0] exp_q;
    logic        exp_e;
    logic [15:0] oq;
    logic        odone, oerr;
    int          av, bv, edges, exp_edges;
    logic [2:0]  op;
    cur_w = w;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      av = $urandom_range(0, (1 << w) - 1);
      bv = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, (1 << w) - 1);
      model(w, op, av, bv, exp_q, exp_e);
      sel_s = op; a_s = 8'(av); b_s = 8'(bv); start_s = 1'b1;
      @(posedge clk);
      edges = 0;
      @(negedge clk);
      start_s = 1'b0;
      odone = (w == 3) ? done3 : done8;
      while (!odone && edges < 20) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
        odone = (w == 3) ? done3 : done8;
      end
      oq   = (w == 3) ? {10'd0, q3} : q8;
      oerr = (w == 3) ? err3 : err8;
      exp_edges = (op == 3'd4 || op == 3'd5) ? w + 1 : 0;
      expect_eq($sformatf("w%0d op%0d a%0d b%0d latency", w, op, av, bv), edges, exp_edges);
      expect_eq($sformatf("w%0d op%0d a%0d b%0d q", w, op, av, bv), oq, exp_q);
      expect_eq($sformatf("w%0d op%0d a%0d b%0d err", w, op, av, bv), oerr, exp_e);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expect_eq("reset q", q4, 8'h00);
    expect_eq("reset busy", busy4, 1'b0);
    expect_eq("reset done", done4, 1'b0);
    expect_eq("reset err", err4, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    do_op4(3'b000, 4'd15, 4'd1, 8'h10, 1'b0, 1'b0, "add 15+1");
    do_op4(3'b001, 4'd3,  4'd5, 8'h1E, 1'b0, 1'b0, "sub 3-5");
    do_op4(3'b010, 4'd7,  4'd7, 8'h01, 1'b0, 1'b0, "eq 7,7");
    do_op4(3'b010, 4'd7,  4'd6, 8'h00, 1'b0, 1'b0, "eq 7,6");
    do_op4(3'b011, 4'd5,  4'd9, 8'h02, 1'b0, 1'b0, "halve 5");
    do_op4(3'b100, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, "mul 15x15");
    do_op4(3'b101, 4'd13, 4'd4, 8'h13, 1'b0, 1'b0, "div 13/4");
    do_op4(3'b101, 4'd9,  4'd0, 8'h9F, 1'b1, 1'b0, "div 9/0");
    do_op4(3'b000, 4'd1,  4'd2, 8'h03, 1'b0, 1'b0, "add clears err");
    do_op4(3'b100, 4'd6,  4'd7, 8'h2A, 1'b0, 1'b1, "mul 6x7 poked");
    do_op4(3'b110, 4'd3,  4'd3, 8'h00, 1'b1, 1'b0, "reserved 110");
    do_op4(3'b111, 4'd9,  4'd2, 8'h00, 1'b1, 1'b0, "reserved 111");
    do_op4(3'b000, 4'd2,  4'd3, 8'h05, 1'b0, 1'b0, "add 2+3");

    sel4 = 3'b101; a4 = 4'd13; b4 = 4'd4; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_eq("mid-div busy", busy4, 1'b1);
    expect_eq("mid-div q held", q4, 8'h05);
    #1 rst = 1'b1;
    #1;
    expect_eq("abort q", q4, 8'h00);
    expect_eq("abort busy", busy4, 1'b0);
    expect_eq("abort done", done4, 1'b0);
    expect_eq("abort err", err4, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op4(3'b000, 4'd2, 4'd2, 8'h04, 1'b0, 1'b0, "add 2+2 after abort");

    rand_ops(3, 40);
    rand_ops(8, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
